// File: rtl/ext_stream_bridge.sv
// Multi-channel register-to-stream bridge: per-channel TX/RX FIFOs behind a
// single-cycle register port, with DMA slot and level-sensitive interrupt outputs.
module ext_stream_bridge #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 8,
    parameter int DW     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 reg_valid_i,
    input  logic                 reg_write_i,
    input  logic [31:0]          reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    input  logic [3:0]           reg_wstrb_i,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_error_o,
    output logic                 reg_ready_o,
    output logic [NUM_CH-1:0]    tx_valid_o,
    output logic [NUM_CH*DW-1:0] tx_data_o,
    input  logic [NUM_CH-1:0]    tx_ready_i,
    input  logic [NUM_CH-1:0]    rx_valid_i,
    input  logic [NUM_CH*DW-1:0] rx_data_i,
    output logic [NUM_CH-1:0]    dma_slot_tx_o,
    output logic [NUM_CH-1:0]    dma_slot_rx_o,
    output logic [NUM_CH-1:0]    intr_o
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [7:0] LVL_FULL = 8'(DEPTH);
    localparam logic [4:0] NCH      = 5'(NUM_CH);

    logic [DW-1:0] tx_mem_q [NUM_CH][DEPTH];
    logic [DW-1:0] rx_mem_q [NUM_CH][DEPTH];
    logic [AW-1:0] tx_wp_q [NUM_CH];
    logic [AW-1:0] tx_wp_d [NUM_CH];
    logic [AW-1:0] tx_rp_q [NUM_CH];
    logic [AW-1:0] tx_rp_d [NUM_CH];
    logic [AW-1:0] rx_wp_q [NUM_CH];
    logic [AW-1:0] rx_wp_d [NUM_CH];
    logic [AW-1:0] rx_rp_q [NUM_CH];
    logic [AW-1:0] rx_rp_d [NUM_CH];
    logic [7:0]    tx_lvl_q [NUM_CH];
    logic [7:0]    tx_lvl_d [NUM_CH];
    logic [7:0]    rx_lvl_q [NUM_CH];
    logic [7:0]    rx_lvl_d [NUM_CH];
    logic [7:0]    thr_q [NUM_CH];
    logic [7:0]    thr_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d, intr_q, intr_d;

    logic [NUM_CH-1:0] tx_full_s, tx_empty_s, rx_full_s, rx_empty_s, ch_hit_s;
    logic [NUM_CH-1:0] tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, ctrl_wr_s, flush_s;
    logic [3:0]        ch_s;
    logic [1:0]        sel_s;
    logic              ch_ok_s, strb_ok_s, acc_ok_s;
    logic              sel_tx_full_s, sel_rx_empty_s;
    logic [31:0]       sel_status_s, sel_ctrl_s, sel_head_s, rdata_s;
    logic              err_s, do_txw_s, do_rxr_s, do_ctrlw_s;
    logic              unused_s;

    assign ch_s      = reg_addr_i[7:4];
    assign sel_s     = reg_addr_i[3:2];
    assign ch_ok_s   = ({1'b0, ch_s} < NCH);
    assign strb_ok_s = (reg_wstrb_i == 4'hF);
    assign acc_ok_s  = ch_ok_s & (~reg_write_i | strb_ok_s);
    assign unused_s  = ^{reg_addr_i[31:8], reg_addr_i[1:0], reg_wdata_i};

    // Per-channel flags, stream/DMA outputs and the register-selected channel view.
    always_comb begin
        sel_tx_full_s  = 1'b0;
        sel_rx_empty_s = 1'b0;
        sel_status_s   = 32'h0;
        sel_ctrl_s     = 32'h0;
        sel_head_s     = 32'h0;
        for (int c = 0; c < NUM_CH; c++) begin
            tx_full_s[c]  = (tx_lvl_q[c] == LVL_FULL);
            tx_empty_s[c] = (tx_lvl_q[c] == 8'd0);
            rx_full_s[c]  = (rx_lvl_q[c] == LVL_FULL);
            rx_empty_s[c] = (rx_lvl_q[c] == 8'd0);
            ch_hit_s[c]   = (ch_s == 4'(c));
            tx_valid_o[c]    = en_q[c] & ~tx_empty_s[c];
            tx_data_o[c*DW +: DW] = tx_mem_q[c][tx_rp_q[c]];
            dma_slot_tx_o[c] = en_q[c] & ~tx_full_s[c];
            dma_slot_rx_o[c] = en_q[c] & ~rx_empty_s[c];
            tx_pop_s[c]  = en_q[c] & ~tx_empty_s[c] & tx_ready_i[c];
            rx_push_s[c] = en_q[c] & rx_valid_i[c] & ~rx_full_s[c];
            sel_tx_full_s  = sel_tx_full_s  | (ch_hit_s[c] & tx_full_s[c]);
            sel_rx_empty_s = sel_rx_empty_s | (ch_hit_s[c] & rx_empty_s[c]);
            sel_status_s = sel_status_s | ({32{ch_hit_s[c]}} &
                {8'h00, rx_lvl_q[c], tx_lvl_q[c], 5'h00, ovf_q[c], rx_empty_s[c], tx_full_s[c]});
            sel_ctrl_s = sel_ctrl_s | ({32{ch_hit_s[c]}} &
                {16'h0000, thr_q[c], 6'h00, irq_en_q[c], en_q[c]});
            sel_head_s = sel_head_s | ({32{ch_hit_s[c]}} & 32'(rx_mem_q[c][rx_rp_q[c]]));
        end
    end

    // Register access decode: read data, error and the side-effect strobes.
    always_comb begin
        rdata_s    = 32'h0;
        err_s      = 1'b0;
        do_txw_s   = 1'b0;
        do_rxr_s   = 1'b0;
        do_ctrlw_s = 1'b0;
        if (!reg_valid_i) begin
            err_s = 1'b0;
        end else if (!acc_ok_s) begin
            err_s = 1'b1;
        end else begin
            case (sel_s)
                2'd0: begin
                    if (reg_write_i && !sel_tx_full_s) do_txw_s = 1'b1;
                    else err_s = 1'b1;
                end
                2'd1: begin
                    if (!reg_write_i && !sel_rx_empty_s) begin
                        do_rxr_s = 1'b1;
                        rdata_s  = sel_head_s;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                2'd2: begin
                    if (!reg_write_i) rdata_s = sel_status_s;
                    else err_s = 1'b1;
                end
                2'd3: begin
                    if (reg_write_i) do_ctrlw_s = 1'b1;
                    else rdata_s = sel_ctrl_s;
                end
                default: err_s = 1'b1;
            endcase
        end
    end

    assign tx_push_s   = {NUM_CH{do_txw_s}} & ch_hit_s;
    assign rx_pop_s    = {NUM_CH{do_rxr_s}} & ch_hit_s;
    assign ctrl_wr_s   = {NUM_CH{do_ctrlw_s}} & ch_hit_s;
    assign flush_s     = ctrl_wr_s & {NUM_CH{reg_wdata_i[31]}};
    assign reg_rdata_o = rdata_s;
    assign reg_error_o = err_s;
    assign reg_ready_o = 1'b1;
    assign intr_o      = intr_q;

    // Next-state for pointers, levels, control and the post-edge interrupt condition.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (ctrl_wr_s[c]) begin
                en_d[c]     = reg_wdata_i[0];
                irq_en_d[c] = reg_wdata_i[1];
                thr_d[c]    = reg_wdata_i[15:8];
            end else begin
                en_d[c]     = en_q[c];
                irq_en_d[c] = irq_en_q[c];
                thr_d[c]    = thr_q[c];
            end
            if (flush_s[c]) begin
                tx_wp_d[c]  = '0;
                tx_rp_d[c]  = '0;
                rx_wp_d[c]  = '0;
                rx_rp_d[c]  = '0;
                tx_lvl_d[c] = 8'd0;
                rx_lvl_d[c] = 8'd0;
                ovf_d[c]    = 1'b0;
            end else begin
                tx_wp_d[c]  = tx_push_s[c] ? tx_wp_q[c] + AW'(1) : tx_wp_q[c];
                tx_rp_d[c]  = tx_pop_s[c]  ? tx_rp_q[c] + AW'(1) : tx_rp_q[c];
                rx_wp_d[c]  = rx_push_s[c] ? rx_wp_q[c] + AW'(1) : rx_wp_q[c];
                rx_rp_d[c]  = rx_pop_s[c]  ? rx_rp_q[c] + AW'(1) : rx_rp_q[c];
                tx_lvl_d[c] = tx_lvl_q[c] + {7'd0, tx_push_s[c]} - {7'd0, tx_pop_s[c]};
                rx_lvl_d[c] = rx_lvl_q[c] + {7'd0, rx_push_s[c]} - {7'd0, rx_pop_s[c]};
                ovf_d[c]    = ovf_q[c] | (en_q[c] & rx_valid_i[c] & rx_full_s[c]);
            end
            intr_d[c] = irq_en_d[c] &
                (((thr_d[c] != 8'd0) & (rx_lvl_d[c] >= thr_d[c])) | ovf_d[c]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tx_wp_q[c]  <= '0;
                tx_rp_q[c]  <= '0;
                rx_wp_q[c]  <= '0;
                rx_rp_q[c]  <= '0;
                tx_lvl_q[c] <= 8'd0;
                rx_lvl_q[c] <= 8'd0;
                thr_q[c]    <= 8'd0;
            end
            en_q     <= '0;
            irq_en_q <= '0;
            ovf_q    <= '0;
            intr_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                tx_wp_q[c]  <= tx_wp_d[c];
                tx_rp_q[c]  <= tx_rp_d[c];
                rx_wp_q[c]  <= rx_wp_d[c];
                rx_rp_q[c]  <= rx_rp_d[c];
                tx_lvl_q[c] <= tx_lvl_d[c];
                rx_lvl_q[c] <= rx_lvl_d[c];
                thr_q[c]    <= thr_d[c];
            end
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            intr_q   <= intr_d;
        end
    end

    // FIFO storage; contents beyond the level are don't-care, so no reset.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (tx_push_s[c] && !flush_s[c]) begin
                tx_mem_q[c][tx_wp_q[c]] <= reg_wdata_i[DW-1:0];
            end
            if (rx_push_s[c] && !flush_s[c]) begin
                rx_mem_q[c][rx_wp_q[c]] <= rx_data_i[c*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_ext_stream_bridge.sv
// Scoreboard bench for ext_stream_bridge: a queue-based channel model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_ext_stream_bridge;

    localparam int NC = 2;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst_i, reg_valid_i, reg_write_i;
    logic [31:0]   reg_addr_i, reg_wdata_i, reg_rdata_o;
    logic [3:0]    reg_wstrb_i;
    logic          reg_error_o, reg_ready_o;
    logic [NC-1:0] tx_valid_o, tx_ready_i, rx_valid_i, dma_slot_tx_o, dma_slot_rx_o, intr_o;
    logic [63:0]   tx_data_o, rx_data_i;

    always #5 clk = ~clk;

    ext_stream_bridge #(.NUM_CH(NC), .DEPTH(DP), .DW(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
        .reg_wdata_i(reg_wdata_i), .reg_wstrb_i(reg_wstrb_i), .reg_rdata_o(reg_rdata_o),
        .reg_error_o(reg_error_o), .reg_ready_o(reg_ready_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .dma_slot_tx_o(dma_slot_tx_o), .dma_slot_rx_o(dma_slot_rx_o), .intr_o(intr_o)
    );

    typedef struct {
        bit          chk_reg;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  txv;
        logic [63:0] txd;
        logic [63:0] txm;
        logic [1:0]  dtx;
        logic [1:0]  drx;
        logic [1:0]  intr;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;

    // Behavioural channel model
    logic [31:0] txq [NC][$];
    logic [31:0] rxq [NC][$];
    bit          m_en [NC];
    bit          m_irq [NC];
    int          m_thr [NC];
    bit          m_ovf [NC];
    bit          m_intr [NC];
    logic [1:0]  rdy_g = 2'b00;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            txq[c].delete();
            rxq[c].delete();
            m_en[c] = 0; m_irq[c] = 0; m_thr[c] = 0; m_ovf[c] = 0; m_intr[c] = 0;
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit w, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input logic [1:0] rdy,
                        input logic [1:0] rxv, input logic [63:0] rxd);
        exp_t e;
        int   ch, rg, txs, rxs;
        bit   pre_en;
        bit   txpush [NC];
        bit   rxpop [NC];
        bit   ctrlw [NC];
        @(posedge clk);
        #1;
        rst_i = rst; reg_valid_i = v; reg_write_i = w; reg_addr_i = {24'h0, a};
        reg_wdata_i = wd; reg_wstrb_i = st; tx_ready_i = rdy; rx_valid_i = rxv; rx_data_i = rxd;
        e = '{default: '0};
        for (int c = 0; c < NC; c++) begin
            txpush[c] = 0; rxpop[c] = 0; ctrlw[c] = 0;
            e.txv[c] = m_en[c] && txq[c].size() > 0;
            if (e.txv[c]) begin
                e.txd[c*32 +: 32] = txq[c][0];
                e.txm[c*32 +: 32] = 32'hFFFF_FFFF;
            end
            e.dtx[c]  = m_en[c] && txq[c].size() < DP;
            e.drx[c]  = m_en[c] && rxq[c].size() > 0;
            e.intr[c] = m_intr[c];
        end
        ch = int'(a[7:4]);
        rg = int'(a[3:2]);
        e.chk_reg = 1;
        if (v) begin
            if (ch >= NC || (w && st != 4'hF)) e.err = 1;
            else if (rg == 0) begin
                if (w && txq[ch].size() < DP) txpush[ch] = 1;
                else e.err = 1;
            end else if (rg == 1) begin
                if (!w && rxq[ch].size() > 0) begin rxpop[ch] = 1; e.rdata = rxq[ch][0]; end
                else e.err = 1;
            end else if (rg == 2) begin
                if (w) e.err = 1;
                else e.rdata = {8'h0, 8'(rxq[ch].size()), 8'(txq[ch].size()), 5'h0,
                                m_ovf[ch], rxq[ch].size() == 0, txq[ch].size() == DP};
            end else begin
                if (w) ctrlw[ch] = 1;
                else e.rdata = {16'h0, 8'(m_thr[ch]), 6'h0, m_irq[ch], m_en[ch]};
            end
        end
        expq.push_back(e);
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < NC; c++) begin
                txs = txq[c].size(); rxs = rxq[c].size(); pre_en = m_en[c];
                if (ctrlw[c]) begin m_en[c] = wd[0]; m_irq[c] = wd[1]; m_thr[c] = int'(wd[15:8]); end
                if (ctrlw[c] && wd[31]) begin
                    txq[c].delete(); rxq[c].delete(); m_ovf[c] = 0;
                end else begin
                    if (pre_en && txs > 0 && rdy[c]) void'(txq[c].pop_front());
                    if (txpush[c]) txq[c].push_back(wd);
                    if (rxpop[c]) void'(rxq[c].pop_front());
                    if (pre_en && rxv[c]) begin
                        if (rxs < DP) rxq[c].push_back(rxd[c*32 +: 32]);
                        else m_ovf[c] = 1;
                    end
                end
                m_intr[c] = m_irq[c] && ((m_thr[c] != 0 && rxq[c].size() >= m_thr[c]) || m_ovf[c]);
            end
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(0, 1, 1, a, d, 4'hF, rdy_g, 2'b00, 64'h0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(0, 1, 0, a, 32'h0, 4'hF, rdy_g, 2'b00, 64'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 8'h0, 32'h0, 4'h0, rdy_g, 2'b00, 64'h0);
    endtask

    task automatic rxp(input int c, input logic [31:0] d);
        logic [63:0] rxd;
        rxd = 64'h0;
        rxd[c*32 +: 32] = d;
        step(0, 0, 0, 8'h0, 32'h0, 4'h0, rdy_g, 2'(1 << c), rxd);
    endtask

    // Monitor: pops one expectation per cycle and compares at the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                mon_e = expq.pop_front();
                check("rdata", reg_rdata_o, mon_e.rdata);
                check("error", reg_error_o, mon_e.err);
                check("ready", reg_ready_o, 1);
                check("tx_valid", tx_valid_o, mon_e.txv);
                check("tx_data", tx_data_o & mon_e.txm, mon_e.txd);
                check("dma_tx", dma_slot_tx_o, mon_e.dtx);
                check("dma_rx", dma_slot_rx_o, mon_e.drx);
                check("intr", intr_o, mon_e.intr);
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  st;
        bit          w, v;
        rst_i = 1; reg_valid_i = 0; reg_write_i = 0; reg_addr_i = 0; reg_wdata_i = 0;
        reg_wstrb_i = 0; tx_ready_i = 0; rx_valid_i = 0; rx_data_i = 0;
        model_reset();
        repeat (3) @(posedge clk);

        rd(8'h08);
        wr(8'h0C, 32'h1);
        wr(8'h00, 32'hA5);
        idle(1);
        rd(8'h08);
        rdy_g = 2'b01; idle(2); rdy_g = 2'b00;
        for (int i = 0; i < 9; i++) wr(8'h00, 32'h100 + 32'(i));
        rd(8'h08);
        rdy_g = 2'b01; idle(10); rdy_g = 2'b00;

        wr(8'h1C, 32'h0000_0303);
        for (int i = 0; i < 3; i++) rxp(1, 32'hC0DE_0000 + 32'(i));
        idle(2);
        rd(8'h14);
        idle(2);
        for (int i = 0; i < 10; i++) rxp(1, 32'hBEEF_0000 + 32'(i));
        idle(1);
        rd(8'h18);
        wr(8'h1C, 32'h8000_0303);
        idle(2);
        rd(8'h18);

        rd(8'h20);
        wr(8'h20, 32'h1);
        step(0, 1, 1, 8'h0C, 32'h0, 4'h3, 2'b00, 2'b00, 64'h0);
        rd(8'h0C);
        rd(8'h14);
        rd(8'h04);

        for (int i = 0; i < 2000; i++) begin
            v  = ($urandom_range(0, 2) != 0);
            a  = {4'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'b00};
            w  = (a[3:2] == 2'd0) ? ($urandom_range(0, 5) != 0) :
                 (a[3:2] == 2'd1) ? ($urandom_range(0, 7) == 0) : 1'($urandom);
            st = ($urandom_range(0, 15) == 0) ? 4'h3 : 4'hF;
            if (a[3:2] == 2'd3)
                d = {1'($urandom_range(0, 11) == 0), 15'($urandom), 8'($urandom_range(0, 9)),
                     6'h0, 1'($urandom), 1'($urandom_range(0, 7) != 0)};
            else
                d = $urandom;
            step(($urandom_range(0, 399) == 0), v, w, a, d, st, 2'($urandom),
                 {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)},
                 {$urandom, $urandom});
        end

        idle(2);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drain", 64'(expq.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ext_stream_bridge.md
Name: ext_stream_bridge

Overview:
Parametrised multi-channel external peripheral that supersedes the single-channel template register peripheral on the external peripheral port. Each channel has a TX FIFO, written over the register interface and drained to an external stream, and an RX FIFO, filled from an external stream and read over the register interface. Per-channel DMA slot and interrupt outputs connect to the X-HEEP external DMA slot and interrupt vectors.

Parameters:
NUM_CH, 2, number of channels (1..8)
DEPTH, 8, entries per FIFO; power of 2, 2..128
DW, 32, stream data width (1..32)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
reg_valid_i  in  1  register request valid
reg_write_i  in  1  1 = write, 0 = read
reg_addr_i  in  32  byte address; only [7:0] decoded
reg_wdata_i  in  32  write data
reg_wstrb_i  in  4  byte strobes
reg_rdata_o  out  32  read data (combinational)
reg_error_o  out  1  access error (combinational)
reg_ready_o  out  1  always 1
tx_valid_o  out  NUM_CH  per-channel TX stream valid
tx_data_o  out  NUM_CH*DW  per-channel TX head data
tx_ready_i  in  NUM_CH  per-channel TX stream ready
rx_valid_i  in  NUM_CH  per-channel RX strobe; no backpressure
rx_data_i  in  NUM_CH*DW  per-channel RX data
dma_slot_tx_o  out  NUM_CH  TX FIFO can accept data
dma_slot_rx_o  out  NUM_CH  RX FIFO holds data
intr_o  out  NUM_CH  per-channel interrupt (registered)

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous and active-high. On reset, FIFOs empty, CTRL=0, overflow flags=0, intr_o=0. Therefore tx_valid_o=0, dma_slot_*=0, reg_rdata_o=0 and reg_error_o=0 while idle.
- Address decode: ch = addr[7:4], reg = addr[3:2]. ch >= NUM_CH gives error=1, rdata=0, no side effect.
- Per-channel map:
  - 0x0 TXDATA (W): pushes wdata[DW-1:0]. If TX is full at the cycle start: error=1, data dropped. Reads return 0 with error=1.
  - 0x4 RXDATA (R): rdata = zero-extended RX head; pops at the clock edge. If empty: rdata=0, error=1, no pop. Writes give error=1.
  - 0x8 STATUS (R): [0] tx_full, [1] rx_empty, [2] rx_overflow (sticky), [15:8] tx_level, [23:16] rx_level. Writes give error=1.
  - 0xC CTRL (RW): [0] enable, [1] irq_en, [15:8] rx_threshold. Writing [31]=1 also flushes both FIFOs and clears overflow in the same edge; bit 31 is self-clearing and reads 0.
- Any write with wstrb != 4'hF gives error=1 and has no effect.
- Register accesses complete in the request cycle (ready=1). Side effects occur at that clock edge.
- TX stream:
  - tx_valid_o[c] = enable & !tx_empty.
  - tx_data_o = head.
  - Pop when valid & ready.
  - enable=0 holds contents; register pushes are still accepted.
- RX stream:
  - When enable=1 and rx_valid_i=1: push if not full.
  - If full, drop the data and set rx_overflow.
  - enable=0: input ignored, no overflow.
- Full/empty checks use the pre-edge state.
  - Simultaneous push and pop on a non-full, non-empty FIFO: both occur, level unchanged.
  - Push onto a full FIFO with a concurrent pop: push rejected, level decreases by 1.
  - Push into an empty FIFO: data visible the next cycle (no fall-through).
- dma_slot_tx_o[c] = enable & !tx_full; dma_slot_rx_o[c] = enable & !rx_empty (combinational).
- Interrupt:
  - Condition: irq_en & ((rx_threshold != 0 & rx_level >= rx_threshold) | rx_overflow).
  - intr_o is a register that takes this condition from post-edge state, so it asserts in the cycle after the condition first holds.
  - Level-sensitive: it deasserts one cycle after a pop or flush removes the condition.
- Levels range 0..DEPTH, held in 8 bits. Pointers wrap modulo DEPTH.
- Flush and reset take precedence over all pushes and pops in the same cycle.
- Reset mid-transfer discards all data with no stream handshake.

Test Plan:
- Reset, NUM_CH=2, DEPTH=8: read STATUS ch0 = 0x00000002. tx_valid_o=0, dma_slot_*=0, intr_o=0.
- CTRL ch0=0x1; write TXDATA 0xA5 with tx_ready_i=0: tx_valid_o[0]=1, tx_data=0xA5, STATUS tx_level=1. Raise ready: pops in 1 cycle, dma_slot_tx_o[0] stays 1.
- Nine TXDATA writes with ready=0: first 8 give error=0, the 9th gives error=1. tx_full=1, dma_slot_tx_o[0]=0. Drain shows 8 values in write order.
- CTRL ch1 = 0x0000_0303 (enable, irq, threshold 3). Push 3 rx words: intr_o[1]=1 one cycle after the third. One RXDATA read returns the first word and intr_o[1] drops the next cycle.
- Fill RX ch1 with 8 words, then a 9th: rx_overflow=1 and intr held. Write CTRL 0x8000_0303: rx_level=0, overflow=0, intr_o[1]=0 next cycle.
- Access addr 0x20 (ch2, NUM_CH=2) and a CTRL write with wstrb=4'h3: error=1, no state change. RXDATA read on empty: rdata=0, error=1.
